// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline definitions for the front-end hazard controller:
// register index width, the hard-wired zero register and the FSM encoding.
package hazard_ctrl_pkg;

  localparam int REG_W = 5;

  typedef logic [REG_W-1:0] reg_idx_t;

  localparam reg_idx_t ZERO_REG = '0;

  localparam logic [0:0] STATE_RUN   = 1'b0;
  localparam logic [0:0] STATE_STALL = 1'b1;

  // A source depends on a destination only if it is actually read and the
  // destination is not the zero register, which never carries a dependency.
  function automatic logic reg_match(input logic     uses,
                                     input reg_idx_t src,
                                     input reg_idx_t dst);
    return uses && (src == dst) && (dst != ZERO_REG);
  endfunction

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones
// instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  always_ff @(posedge clk) begin
    if (clear) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + ONE;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard and redirect controller: stalls the front end on load-use and
// branch-operand hazards, flushes IF on taken branches/jumps, counts both.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             id_is_branch,
  input  logic             branch_taken,
  input  logic             jump,
  input  logic             ex_reg_write,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rd,
  input  logic             mem_mem_read,
  input  logic [4:0]       mem_rd,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             idex_bubble,
  output logic             if_flush,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  logic [0:0] state, state_next;
  logic [1:0] rem, rem_next;
  logic [1:0] need;
  logic       ex_hit, mem_hit;
  logic       stall;

  assign ex_hit  = reg_match(id_uses_rs, id_rs, ex_rd)  || reg_match(id_uses_rt, id_rt, ex_rd);
  assign mem_hit = reg_match(id_uses_rs, id_rs, mem_rd) || reg_match(id_uses_rt, id_rt, mem_rd);

  // Required stall depth; the strongest hazard wins. A branch waiting on a
  // load in EX needs two cycles because it compares operands in ID.
  // NOTE: always_comb assigns every output a default first so no latch is inferred.
  always_comb begin
    need = 2'd0;
    if (ex_mem_read && ex_hit) need = 2'd1;
    if (id_is_branch) begin
      if (ex_reg_write && !ex_mem_read && ex_hit) need = 2'd1;
      if (mem_mem_read && mem_hit)                need = 2'd1;
      if (ex_mem_read && ex_hit)                  need = 2'd2;
    end
  end

  // Reset forces run defaults; STALL ignores all hazard and redirect inputs.
  assign stall       = !reset && ((state == STATE_STALL) || (need != 2'd0));
  assign pc_write    = !stall;
  assign ifid_write  = !stall;
  assign idex_bubble = stall;
  assign if_flush    = !reset && !stall && (jump || (id_is_branch && branch_taken));

  always_comb begin
    state_next = state;
    rem_next   = rem;
    case (state)
      STATE_RUN: begin
        if (need == 2'd2) begin
          state_next = STATE_STALL;
          rem_next   = 2'd1;
        end
      end
      STATE_STALL: begin
        rem_next = rem - 2'd1;
        if (rem <= 2'd1) begin
          state_next = STATE_RUN;
          rem_next   = 2'd0;
        end
      end
      default: begin
        state_next = STATE_RUN;
        rem_next   = 2'd0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= STATE_RUN;
      rem   <= 2'd0;
    end else begin
      state <= state_next;
      rem   <= rem_next;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .clear (reset),
    .inc   (!pc_write),
    .count (stall_cycles)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .clear (reset),
    .inc   (if_flush),
    .count (flush_count)
  );

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Hazard and redirect controller for the 5-stage pipeline front end. It decides each cycle whether the PC and IF/ID register advance, whether a bubble goes into ID/EX, and whether the fetched instruction is flushed on a taken branch or jump. It detects load-use and branch-operand hazards, holds multi-cycle stalls with a small FSM, and keeps saturating performance counters. It sits between the ID stage (decoded sources, branch/jump decision) and the EX/MEM pipeline registers (destination info).

Parameters:
CNT_W, 16, width of the stall_cycles and flush_count performance counters

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
id_rs  in  5  rs field of instruction in ID
id_rt  in  5  rt field of instruction in ID
id_uses_rs  in  1  ID instruction reads rs
id_uses_rt  in  1  ID instruction reads rt
id_is_branch  in  1  ID instruction is a conditional branch (compared in ID)
branch_taken  in  1  ID branch comparison result (valid only when operands ready)
jump  in  1  ID instruction is an unconditional jump
ex_reg_write  in  1  EX instruction writes a register
ex_mem_read  in  1  EX instruction is a load
ex_rd  in  5  EX destination register
mem_mem_read  in  1  MEM instruction is a load
mem_rd  in  5  MEM destination register
pc_write  out  1  1 = PC loads next value
ifid_write  out  1  1 = IF/ID register loads
idex_bubble  out  1  1 = ID/EX loads a NOP
if_flush  out  1  1 = PC takes redirect target, IF/ID loads a NOP
stall_cycles  out  CNT_W  count of cycles with stall asserted, saturating
flush_count  out  CNT_W  count of cycles with if_flush asserted, saturating

Behaviour:
- Match(a,r) = uses_a && (src == r) && (r != 0). Register 0 never creates a hazard.
- The required stall count N is computed combinationally in RUN:
  - Load-use: ex_mem_read and Match(rs|rt, ex_rd) gives N=1.
  - If id_is_branch:
    - ex_reg_write and not ex_mem_read and Match(ex_rd) gives N=1.
    - ex_mem_read and Match(ex_rd) gives N=2.
    - mem_mem_read and Match(mem_rd) gives N=1.
  - When several conditions hold, N is the maximum.
- FSM states RUN and STALL, with 2-bit remaining counter rem.
  - RUN, N=0: pc_write=1, ifid_write=1, idex_bubble=0. if_flush = jump | (id_is_branch & branch_taken).
  - RUN, N>0: stall this cycle (pc_write=0, ifid_write=0, idex_bubble=1, if_flush=0).
    - If N=1, stay in RUN; re-evaluation next cycle sees the advanced pipeline.
    - If N=2, go to STALL with rem=1.
  - STALL: stall outputs as above, ignore all hazard inputs, branch_taken and jump. rem decrements; at rem=0 return to RUN. This adds exactly one extra stall cycle.
- A stall has priority over a flush: branch_taken is not trusted while operands are pending. jump is never subject to operand hazards, so jump with N=0 flushes immediately.
- Outputs are combinational from state and inputs (zero latency). The only registered state is FSM, rem and the counters.
- Counters:
  - stall_cycles increments on each cycle where pc_write=0.
  - flush_count increments on each cycle where if_flush=1.
  - Both hold at all-ones (no wrap).
- Reset (synchronous, any state including mid-STALL):
  - State goes to RUN, rem=0, and both counters go to 0 on the next edge.
  - While reset=1, outputs are forced to pc_write=1, ifid_write=1, idex_bubble=0, if_flush=0.
- A stall and a flush never assert together. idex_bubble always equals ~pc_write.

Decomposition:
- Shared pipeline package holds the register-index width (5), the zero-register constant, and the FSM state encoding (RUN=0, STALL=1).
- One natural sub-module, sat_counter (CNT_W, inc, clear), instantiated twice for the performance counters.

Test Plan:
1. Load-use: ex_mem_read=1, ex_rd=8, id_rs=8, id_uses_rs=1 -> one cycle of pc_write=0, idex_bubble=1. Next cycle with ex_mem_read=0 -> pc_write=1. stall_cycles=1.
2. Load then branch: id_is_branch=1, ex_mem_read=1, ex_rd=9, id_rt=9 -> exactly 2 stall cycles (RUN then STALL), no if_flush even with branch_taken=1 during them. stall_cycles=2.
3. ALU then branch: ex_reg_write=1, ex_mem_read=0, ex_rd=5, id_rs=5, id_is_branch=1 -> 1 stall. Next cycle with no hazard and branch_taken=1 -> if_flush=1, flush_count=1.
4. Zero register: ex_mem_read=1, ex_rd=0, id_rs=0 -> no stall. jump=1 in the same cycle -> if_flush=1.
5. Reset mid-STALL: enter STALL via scenario 2, assert reset for 1 cycle -> outputs at run defaults during reset. Afterwards state is RUN and both counters read 0.
6. Saturation: with CNT_W=4, hold a load-use hazard for 20 cycles -> stall_cycles stops at 15 and does not wrap.
